// File: rtl/height_pkg.sv
// rtl/height_pkg.sv - shared types and default sizes for the height pipeline
package height_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        BROWSE = 1'b1
    } hist_state_t;

    localparam int HEIGHT_WIDTH = 8;
    localparam int HIST_DEPTH   = 10;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchroniser, stability counter and press pulse for an active-low button
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            // Any cycle agreeing with the stable level restarts the run.
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= ~sync2;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/history_browser.sv
// rtl/history_browser.sv - ring buffer of recent height samples with button-driven browsing
module history_browser
    import height_pkg::*;
#(
    parameter int WIDTH           = HEIGHT_WIDTH,
    parameter int DEPTH           = HIST_DEPTH,
    parameter int DEBOUNCE_CYCLES = 1048576,
    parameter int TIMEOUT_CYCLES  = 60000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [WIDTH-1:0]           sample_data,
    input  logic                       clr,
    input  logic                       btn_next_n,
    input  logic                       btn_prev_n,
    output logic [WIDTH-1:0]           disp_value,
    output logic [$clog2(DEPTH)-1:0]   disp_age,
    output logic                       disp_live,
    output logic [$clog2(DEPTH+1)-1:0] hist_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] AGE_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    age;
    logic [AW-1:0]    rd_addr;
    logic [TW-1:0]    tmo;
    hist_state_t      state;
    logic             next_p;
    logic             prev_p;
    logic             tmo_done;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_next_n),
        .press (next_p)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_prev_n),
        .press (prev_p)
    );

    // (wr_ptr - 1 - age) mod DEPTH; the else branch may overflow AW bits mid-sum but lands in range.
    always_comb begin
        rd_addr = '0;
        if (wr_ptr > age) rd_addr = wr_ptr - age - AW'(1);
        else              rd_addr = wr_ptr + AGE_LAST - age;
    end

    assign tmo_done = (tmo <= TW'(1));

    always_ff @(posedge clk) begin
        if (rst_n && !clr && sample_valid) mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr     <= '0;
            hist_count <= '0;
            state      <= LIVE;
            age        <= '0;
            tmo        <= '0;
        end else begin
            if (sample_valid) begin
                wr_ptr <= (wr_ptr == AGE_LAST) ? '0 : wr_ptr + AW'(1);
                if (hist_count != CNT_FULL) hist_count <= hist_count + CW'(1);
            end
            case (state)
                LIVE: begin
                    age <= '0;
                    if (next_p && !prev_p && hist_count >= CW'(2)) begin
                        state <= BROWSE;
                        age   <= AW'(1);
                        tmo   <= TMO_LOAD;
                    end
                end
                BROWSE: begin
                    // A write shifts age to keep the same entry selected and swallows any button pulse.
                    if (sample_valid) begin
                        if ((age == AGE_LAST && hist_count == CNT_FULL) || tmo_done) begin
                            state <= LIVE;
                            age   <= '0;
                        end else begin
                            age <= age + AW'(1);
                            tmo <= tmo - TW'(1);
                        end
                    end else if (next_p || prev_p) begin
                        tmo <= TMO_LOAD;
                        if (next_p && !prev_p)
                            age <= (CW'(age) == hist_count - CW'(1)) ? '0 : age + AW'(1);
                        else if (prev_p && !next_p)
                            age <= (age == '0) ? AW'(hist_count - CW'(1)) : age - AW'(1);
                    end else if (tmo_done) begin
                        state <= LIVE;
                        age   <= '0;
                    end else begin
                        tmo <= tmo - TW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_value <= '0;
            disp_age   <= '0;
            disp_live  <= 1'b1;
        end else begin
            disp_value <= (hist_count == '0) ? '0 : mem[rd_addr];
            disp_age   <= age;
            disp_live  <= (state == LIVE);
        end
    end

endmodule

// File: tb/tb_history_browser.sv
// tb/tb_history_browser.sv - vector table, directed sequences and random run against a queue model
module tb_history_browser;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int DEB = 4;
    localparam int TMO = 50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sample_valid;
    logic [W-1:0] sample_data;
    logic         clr;
    logic         btn_next_n;
    logic         btn_prev_n;
    logic [W-1:0] disp_value;
    logic [1:0]   disp_age;
    logic         disp_live;
    logic [2:0]   hist_count;

    history_browser #(
        .WIDTH(W), .DEPTH(D), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .clr          (clr),
        .btn_next_n   (btn_next_n),
        .btn_prev_n   (btn_prev_n),
        .disp_value   (disp_value),
        .disp_age     (disp_age),
        .disp_live    (disp_live),
        .hist_count   (hist_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: newest sample at q[0]; browsing age; absolute edge at which browsing expires.
    int q[$];
    int m_age = 0;
    bit m_live = 1;
    int m_deadline = -1;
    int e = 0;
    int x_val, x_age, x_live, x_cnt;
    bit nsched[int];
    bit psched[int];

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, exp);
        end
    endfunction

    task automatic model_edge();
        bit nx, pv;
        int cnt;
        nx = nsched.exists(e);
        pv = psched.exists(e);
        if (!rst_n) begin
            x_val = 0; x_age = 0; x_live = 1;
            q.delete(); m_age = 0; m_live = 1;
        end else begin
            x_live = m_live;
            x_age  = m_live ? 0 : m_age;
            x_val  = (q.size() == 0) ? 0 : q[x_age];
            cnt    = q.size();
            if (clr) begin
                q.delete(); m_live = 1; m_age = 0;
            end else begin
                if (sample_valid) begin
                    q.push_front(int'(sample_data));
                    if (q.size() > D) void'(q.pop_back());
                end
                if (m_live) begin
                    if (nx && !pv && cnt >= 2) begin
                        m_live = 0; m_age = 1; m_deadline = e + TMO;
                    end
                end else if (sample_valid) begin
                    if ((m_age == D - 1 && cnt == D) || e == m_deadline) begin
                        m_live = 1; m_age = 0;
                    end else m_age++;
                end else if (nx || pv) begin
                    m_deadline = e + TMO;
                    if (nx && !pv) m_age = (m_age == cnt - 1) ? 0 : m_age + 1;
                    else if (pv && !nx) m_age = (m_age == 0) ? cnt - 1 : m_age - 1;
                end else if (e == m_deadline) begin
                    m_live = 1; m_age = 0;
                end
            end
        end
        x_cnt = q.size();
        e++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("value", int'(disp_value), x_val);
        chk("age",   int'(disp_age),   x_age);
        chk("live",  int'(disp_live),  x_live);
        chk("count", int'(hist_count), x_cnt);
    endtask

    task automatic write(input int v);
        sample_valid = 1'b1; sample_data = W'(v);
        tick();
        sample_valid = 1'b0;
    endtask

    // Clean press: held >= DEB cycles, so the pulse lands DEB+2 edges after the raw fall.
    task automatic press(input bit nxt, input bit prv, output int pe);
        pe = e + DEB + 2;
        if (nxt) begin btn_next_n = 1'b0; nsched[pe] = 1'b1; end
        if (prv) begin btn_prev_n = 1'b0; psched[pe] = 1'b1; end
        repeat (DEB + 2) tick();
        btn_next_n = 1'b1; btn_prev_n = 1'b1;
        repeat (DEB + 4) tick();
    endtask

    typedef struct {
        bit sv;
        int data;
        bit cl;
        int cnt;
        int val;
    } vec_t;

    vec_t vt[9];
    int   low_left[2];
    int   cool[2];

    task automatic rand_buttons(input bit allow);
        for (int b = 0; b < 2; b++) begin
            if (low_left[b] > 0) begin
                low_left[b]--;
                if (low_left[b] == 0) begin
                    if (b == 0) btn_next_n = 1'b1; else btn_prev_n = 1'b1;
                    cool[b] = DEB + 3;
                end
            end else if (cool[b] > 0) begin
                cool[b]--;
            end else if (allow && $urandom_range(0, 19) == 0) begin
                low_left[b] = DEB + int'($urandom_range(0, 3));
                if (b == 0) begin btn_next_n = 1'b0; nsched[e + DEB + 2] = 1'b1; end
                else        begin btn_prev_n = 1'b0; psched[e + DEB + 2] = 1'b1; end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe, p1, p2;
        vt[0] = '{1, 10, 0, 1, 0};
        vt[1] = '{1, 20, 0, 2, 10};
        vt[2] = '{1, 30, 0, 3, 20};
        vt[3] = '{0, 0,  0, 3, 30};
        vt[4] = '{0, 0,  1, 0, 30};
        vt[5] = '{0, 0,  0, 0, 0};
        vt[6] = '{1, 5,  1, 0, 0};
        vt[7] = '{1, 7,  0, 1, 0};
        vt[8] = '{0, 0,  0, 1, 7};

        rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0; clr = 1'b0;
        btn_next_n = 1'b1; btn_prev_n = 1'b1;
        @(negedge clk);
        repeat (2) tick();
        chk("reset_live", int'(disp_live), 1);
        chk("reset_count", int'(hist_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            sample_valid = vt[i].sv; sample_data = W'(vt[i].data); clr = vt[i].cl;
            tick();
            chk("tbl_count", int'(hist_count), vt[i].cnt);
            chk("tbl_value", int'(disp_value), vt[i].val);
            chk("tbl_live",  int'(disp_live),  1);
        end
        sample_valid = 1'b0; clr = 1'b0;

        // Fill with 10..50, then browse with wraparound.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int v = 10; v <= 50; v += 10) write(v);
        tick();
        chk("fill_count", int'(hist_count), 4);
        chk("fill_value", int'(disp_value), 50);
        press(1, 0, pe); chk("next1", int'(disp_value), 40);
        press(1, 0, pe); chk("next2", int'(disp_value), 30);
        press(1, 0, pe); chk("next3", int'(disp_value), 20);
        press(1, 0, pe); chk("next4_wrap", int'(disp_value), 50);
        press(0, 1, pe); chk("prev_wrap", int'(disp_value), 20);
        chk("prev_age", int'(disp_age), 3);

        // Short glitch must not step; a 6-cycle press steps once, visible DEB+4 edges after the fall.
        btn_next_n = 1'b0; repeat (3) tick(); btn_next_n = 1'b1;
        repeat (DEB + 4) tick();
        chk("glitch_age", int'(disp_age), 3);
        btn_next_n = 1'b0; nsched[e + DEB + 2] = 1'b1;
        repeat (DEB + 2) tick();
        btn_next_n = 1'b1;
        tick();
        chk("step_early", int'(disp_age), 3);
        tick();
        chk("step_on_time", int'(disp_age), 0);
        repeat (DEB + 4) tick();
        chk("step_once", int'(disp_age), 0);

        // Writes while browsing keep the selection until it is overwritten.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int v = 10; v <= 50; v += 10) write(v);
        press(1, 0, pe); press(1, 0, pe);
        chk("br_value", int'(disp_value), 30);
        write(60); tick();
        chk("br_w_age", int'(disp_age), 3);
        chk("br_w_value", int'(disp_value), 30);
        write(70); tick();
        chk("br_ovw_live", int'(disp_live), 1);
        chk("br_ovw_value", int'(disp_value), 70);

        // Timeout after a press.
        press(1, 0, pe);
        while (e <= pe + TMO) tick();
        chk("tmo_before", int'(disp_live), 0);
        tick();
        chk("tmo_live", int'(disp_live), 1);
        chk("tmo_value", int'(disp_value), 70);

        // Simultaneous pulses: no step, but timeout reloaded.
        press(1, 0, p1);
        press(1, 1, p2);
        chk("both_age", int'(disp_age), 1);
        while (e <= p1 + TMO + 1) tick();
        chk("both_reload", int'(disp_live), 0);
        while (e <= p2 + TMO + 1) tick();
        chk("both_expire", int'(disp_live), 1);

        // clr while browsing, then next on empty history.
        press(1, 0, pe);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_count", int'(hist_count), 0);
        tick();
        chk("clr_value", int'(disp_value), 0);
        chk("clr_live", int'(disp_live), 1);
        press(1, 0, pe);
        chk("empty_next", int'(disp_live), 1);

        // Reset in the middle of browsing.
        write(1); write(2); write(3);
        press(1, 0, pe);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rst_value", int'(disp_value), 0);
        chk("rst_age", int'(disp_age), 0);
        chk("rst_live", int'(disp_live), 1);
        chk("rst_count", int'(hist_count), 0);

        // Random traffic against the model.
        low_left[0] = 0; low_left[1] = 0; cool[0] = 0; cool[1] = 0;
        for (int i = 0; i < 2500; i++) begin
            sample_valid = ($urandom_range(0, 2) == 0);
            sample_data  = W'($urandom);
            clr          = ($urandom_range(0, 79) == 0);
            rand_buttons(1'b1);
            tick();
        end
        sample_valid = 1'b0; clr = 1'b0;
        for (int i = 0; i < 3 * DEB + 12; i++) begin
            rand_buttons(1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/history_browser.md
# history_browser

Parametrised height-history buffer and browser. Stores the last DEPTH accepted height samples in an internal ring buffer. Lets the user step newer/older with two debounced active-low buttons and returns to the live (newest) value after an idle timeout. Sits between the measurement pipeline and `display_inches`; its `disp_value` drives the display's `inches_display` input.

## Interface
- WIDTH, 8, sample width in bits
- DEPTH, 10, history entries (≥2)
- DEBOUNCE_CYCLES, 1048576, consecutive stable cycles required to accept a button level change
- TIMEOUT_CYCLES, 60000000, idle cycles in BROWSE before returning to LIVE (5 s at 12 MHz)
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- sample_valid  in  1  one-cycle strobe: store sample_data as newest entry
- sample_data  in  WIDTH  height sample
- clr  in  1  synchronous clear of history (level, active-high)
- btn_next_n  in  1  raw button, active-low: step to older entry
- btn_prev_n  in  1  raw button, active-low: step to newer entry
- disp_value  out  WIDTH  selected entry (registered)
- disp_age  out  $clog2(DEPTH)  age of selected entry, 0 = newest
- disp_live  out  1  high in LIVE state
- hist_count  out  $clog2(DEPTH+1)  valid entries, saturates at DEPTH

## Operation
- Reset (rst_n=0 at an edge): wr_ptr=0, hist_count=0, state LIVE, age=0, disp_value=0, disp_age=0, disp_live=1, timeout counter=0, debouncers released (stable=1).
- Write: sample_valid stores sample_data at wr_ptr; wr_ptr wraps DEPTH-1→0; hist_count saturates at DEPTH. Oldest entry is overwritten when full.
- Selected physical address = (wr_ptr − 1 − age) mod DEPTH.
- Buttons: raw input goes through a 2-flop synchroniser, then the debouncer. Stable level changes after DEBOUNCE_CYCLES consecutive differing cycles. A press is a stable 1→0 transition and produces a one-cycle pulse.
- State LIVE: age forced to 0. next pulse with hist_count≥2 → BROWSE, age=1. Otherwise (including prev) it is ignored.
- State BROWSE:
  - next: age = (age==hist_count−1) ? 0 : age+1.
  - prev: age = (age==0) ? hist_count−1 : age−1.
  - Each press reloads the timeout counter.
  - Timeout expiry → LIVE, age=0.
- Both next and prev pulses in the same cycle: both are ignored, but the timeout is still reloaded in BROWSE.
- sample_valid in BROWSE: age increments so the same stored entry stays selected.
  - If age was DEPTH−1 and hist_count==DEPTH, that entry is overwritten, so go → LIVE, age=0.
  - The write takes priority over a same-cycle button pulse; the pulse is dropped.
- clr (and clr with reset): hist_count=0, wr_ptr=0, → LIVE, age=0. Memory contents are not erased. clr has priority over sample_valid in the same cycle.
- Empty (hist_count==0): disp_value=0 regardless of memory.

## Timing
- Pointer, age and state update at edge N. disp_value, disp_age and disp_live reflect them at edge N+1, giving a fixed 1-cycle output latency.
- Write then read: a sample written at edge N appears on disp_value at edge N+1 in LIVE (write-first forwarding, no stale read).
- Button latency: raw falling edge to press pulse = 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES never pulse.
- Timeout: exactly TIMEOUT_CYCLES cycles after the last press or BROWSE entry, the state is LIVE. Counter width is $clog2(TIMEOUT_CYCLES+1).
- A held button generates exactly one pulse. No auto-repeat.

## Structure
- Package `height_pkg`:
  - `hist_state_t` enum {LIVE, BROWSE}
  - default WIDTH/DEPTH localparams shared with the height pipeline
- Sub-module `button_debouncer`, parameters DEBOUNCE_CYCLES, with ports clk, rst_n, btn_n, press. It contains the synchroniser, counter and edge pulse, and is instantiated twice.
- Memory is an inferred register array. No reset on array contents.

## Test plan
Parameters for all scenarios: DEPTH=4, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50.
- Reset, then write 10, 20, 30 → hist_count=3, disp_value=30, disp_live=1, disp_age=0.
- Write 10..50 (5 samples) → hist_count=4. Then press next ×4 → disp_value 40, 30, 20, 50 (wrap); prev once → 20.
- 3-cycle low glitch on btn_next_n → no age change. 6-cycle low → exactly one step, 6 cycles after the raw edge.
- Enter BROWSE at age 2 (value 30 of 10..50), write 60 → disp_age=3, disp_value still 30. Write 70 → LIVE, disp_value=70.
- Press next, then idle 50 cycles → disp_live=1, disp_value=newest. Simultaneous next+prev pulse → age unchanged.
- clr in BROWSE → hist_count=0, disp_value=0, LIVE. Press next → ignored. rst_n low mid-browse → all outputs at reset values next cycle.
